// File: rtl/piso_pkg.sv
// Shared state type and sizing helpers for the PISO serializer.
// Build option PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold FRAME (up to WIDTH+1) without wrapping.
  function automatic int cntWidth(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic int frameLen(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable frame bit counter; o_tc flags the cycle whose bit precedes the
// last frame bit, so the registered done pulse lines up with that last bit.
module piso_bit_counter #(
  parameter int CW = 4,
  parameter int TC = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [CW-1:0] i_loadVal,
  input  logic          i_en,
  output logic          o_tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TC);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, with valid/done framing.
// Define PISO_PARITY_EN to send an even-parity bit after the LSB.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW    = cntWidth(WIDTH);
  localparam int FRAME = frameLen(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shiftNext;
  logic             r_valid;
  logic             w_validNext;
  logic             r_ready;
  logic             w_readyNext;
  logic             r_done;
  logic             w_doneNext;
  logic             w_cntClear;
  logic             w_cntLoad;
  logic             w_cntEn;
  logic             w_tc;
  logic             w_fill;

`ifdef PISO_PARITY_EN
  logic r_parity;
  logic w_parityNext;

  // The parity bit is shifted in behind the data, so it reaches the MSB
  // position right after the LSB has been presented.
  assign w_fill = r_parity;
`else
  assign w_fill = 1'b0;
`endif

  piso_bit_counter #(
    .CW (CW),
    .TC (FRAME - 1)
  ) u_bitCounter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_cntClear),
    .i_load    (w_cntLoad),
    .i_loadVal (CW'(1)),
    .i_en      (w_cntEn),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_shiftNext = r_shift;
    w_validNext = r_valid;
    w_readyNext = r_ready;
    w_doneNext  = 1'b0;
    w_cntClear  = 1'b0;
    w_cntLoad   = 1'b0;
    w_cntEn     = 1'b0;
`ifdef PISO_PARITY_EN
    w_parityNext = r_parity;
`endif
    unique case (r_state)
      IDLE: begin
        w_shiftNext = '0;
        w_validNext = 1'b0;
        w_readyNext = 1'b1;
        if (load) begin
          w_nextState = SHIFT;
          w_shiftNext = din;
          w_validNext = 1'b1;
          w_readyNext = 1'b0;
          w_cntLoad   = 1'b1;
`ifdef PISO_PARITY_EN
          w_parityNext = ^din;
`endif
        end
      end
      SHIFT: begin
        // A registered done marks the last bit; the edge ending it closes the frame.
        if (r_done) begin
          w_nextState = IDLE;
          w_shiftNext = '0;
          w_validNext = 1'b0;
          w_readyNext = 1'b1;
          w_cntClear  = 1'b1;
        end else begin
          w_shiftNext = {r_shift[WIDTH-2:0], w_fill};
          w_cntEn     = 1'b1;
          w_doneNext  = w_tc;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_shift <= w_shiftNext;
      r_valid <= w_validNext;
      r_ready <= w_readyNext;
      r_done  <= w_doneNext;
`ifdef PISO_PARITY_EN
      r_parity <= w_parityNext;
`endif
    end
  end

  assign sout       = r_shift[WIDTH-1];
  assign sout_valid = r_valid;
  assign ready      = r_ready;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and randomized bench for piso_serializer against a bit-stream model.
// Honors PISO_PARITY_EN in the same way as the design.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int lastDoneCycle = -1;
  int doneGap = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .load       (load),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  // Frame bit k of a word: data MSB first, then the even-parity bit.
  function automatic logic expBit(input logic [WIDTH-1:0] word, input int k);
    if (k < WIDTH) return word[WIDTH-1-k];
    return ^word;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, " ready"}, ready, 1);
    checkOutput({tag, " sout"}, sout, 0);
    checkOutput({tag, " sout_valid"}, sout_valid, 0);
    checkOutput({tag, " done"}, done, 0);
  endtask

  // Called at a negedge in an idle cycle; sends one frame and checks the idle gap after it.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input int busyCycle,
                               input logic [WIDTH-1:0] busyWord, input bit holdLoad);
    logic [WIDTH-1:0] cap;
    cap  = '0;
    load = 1'b1;
    din  = word;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      checkOutput($sformatf("word=%0h bit%0d sout", word, k), sout, expBit(word, k));
      checkOutput($sformatf("word=%0h bit%0d sout_valid", word, k), sout_valid, 1);
      checkOutput($sformatf("word=%0h bit%0d ready", word, k), ready, 0);
      checkOutput($sformatf("word=%0h bit%0d done", word, k), done, (k == FRAME - 1));
      if (k < WIDTH) cap = {cap[WIDTH-2:0], sout};
      if (done === 1'b1) begin
        if (lastDoneCycle >= 0) doneGap = cycle - lastDoneCycle;
        lastDoneCycle = cycle;
      end
      if (k + 1 == busyCycle) begin
        load = 1'b1;
        din  = busyWord;
      end else begin
        load = holdLoad;
        din  = WIDTH'($urandom);
      end
    end
    @(negedge clk);
    checkOutput($sformatf("word=%0h capture", word), cap, word);
    expectIdle($sformatf("word=%0h gap", word));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] WIDTH=%0d FRAME=%0d", WIDTH, FRAME);

    rst_n = 1'b0;
    load  = 1'b1;
    din   = '1;
    repeat (3) begin
      @(negedge clk);
      expectIdle("reset");
    end
    rst_n = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    expectIdle("after-reset");

    applyStimulus(8'hA5, 0, '0, 1'b0);
    applyStimulus(8'h3C, 4, 8'hFF, 1'b0);

    lastDoneCycle = -1;
    doneGap = 0;
    applyStimulus(8'h81, 0, '0, 1'b1);
    applyStimulus(8'h7E, 0, '0, 1'b0);
    checkOutput("back-to-back done gap", doneGap, FRAME + 1);

    load = 1'b1;
    din  = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort bit%0d sout", k), sout, expBit(8'hF0, k));
      checkOutput($sformatf("abort bit%0d sout_valid", k), sout_valid, 1);
      load = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 expectIdle("async-abort");
    @(negedge clk);
    expectIdle("abort-held");
    rst_n = 1'b1;
    @(negedge clk);
    expectIdle("abort-released");
    applyStimulus(8'h01, 0, '0, 1'b0);

    applyStimulus(8'h07, 0, '0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(WIDTH'($urandom), int'($urandom_range(0, FRAME - 1)),
                    WIDTH'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
